// File: rtl/aes_job_arbiter.sv
// Arbitrates AES jobs from two requesters onto one shared cipher/inv_cipher core
// and sequences key load, decrypt key expansion and run phases under a watchdog.
module aes_job_arbiter #(
  parameter int TIMEOUT = 31
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [1:0] mode_a,
  input  logic [1:0] mode_b,
  input  logic       dir_a,
  input  logic       dir_b,
  input  logic       core_enc_done,
  input  logic       core_dec_done,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic       err_a,
  output logic       err_b,
  output logic       busy,
  output logic       owner,
  output logic [1:0] core_mode,
  output logic       key_load,
  output logic       key_revers,
  output logic       cipher_reset,
  output logic       cipher_enable,
  output logic       inv_cipher_reset,
  output logic       inv_cipher_enable
);

  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EXPAND, S_REV, S_RUN_ENC, S_RUN_DEC, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             gntA_q, gntA_d, gntB_q, gntB_d;
  logic             doneA_q, doneA_d, doneB_q, doneB_d;
  logic             errA_q, errA_d, errB_q, errB_d;

  logic             grantB;
  logic [1:0]       selMode;
  logic             selDir;
  logic [3:0]       rndLast;

  // On a tie the requester that was not served last wins; last_q resets to B.
  assign grantB  = req_b & (~req_a | ~last_q);
  assign selMode = grantB ? mode_b : mode_a;
  assign selDir  = grantB ? dir_b : dir_a;

  always_comb begin
    case (mode_q)
      2'd1:    rndLast = 4'd11;
      2'd2:    rndLast = 4'd13;
      default: rndLast = 4'd9;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      dir_q   <= 1'b0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
      rnd_q   <= '0;
      wdog_q  <= '0;
      gntA_q  <= 1'b0;
      gntB_q  <= 1'b0;
      doneA_q <= 1'b0;
      doneB_q <= 1'b0;
      errA_q  <= 1'b0;
      errB_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      rnd_q   <= rnd_d;
      wdog_q  <= wdog_d;
      gntA_q  <= gntA_d;
      gntB_q  <= gntB_d;
      doneA_q <= doneA_d;
      doneB_q <= doneB_d;
      errA_q  <= errA_d;
      errB_q  <= errB_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    last_d  = last_q;
    rnd_d   = rnd_q;
    wdog_d  = wdog_q;
    gntA_d  = 1'b0;
    gntB_d  = 1'b0;
    doneA_d = 1'b0;
    doneB_d = 1'b0;
    errA_d  = 1'b0;
    errB_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          state_d = (selMode == 2'd3) ? S_ERR : S_LOAD;
          mode_d  = selMode;
          dir_d   = selDir;
          owner_d = grantB;
          busy_d  = 1'b1;
          gntA_d  = ~grantB;
          gntB_d  = grantB;
        end
      end
      S_LOAD: begin
        state_d = dir_q ? S_EXPAND : S_RUN_ENC;
        rnd_d   = '0;
        wdog_d  = '0;
      end
      S_EXPAND: begin
        if (rnd_q == rndLast) begin
          state_d = S_REV;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_REV: begin
        state_d = S_RUN_DEC;
        wdog_d  = '0;
      end
      // Core completion is checked before the watchdog so a coincident done wins.
      S_RUN_ENC: begin
        if (core_enc_done) begin
          state_d = S_DONE;
        end else if (wdog_q == WD_LAST) begin
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RUN_DEC: begin
        if (core_dec_done) begin
          state_d = S_DONE;
        end else if (wdog_q == WD_LAST) begin
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        doneA_d = ~owner_q;
        doneB_d = owner_q;
        busy_d  = 1'b0;
        last_d  = owner_q;
      end
      S_ERR: begin
        state_d = S_IDLE;
        errA_d  = ~owner_q;
        errB_d  = owner_q;
        busy_d  = 1'b0;
        last_d  = owner_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Core controls decode straight from the state so reset forces them immediately.
  always_comb begin
    key_load          = 1'b1;
    key_revers        = 1'b0;
    cipher_reset      = 1'b1;
    cipher_enable     = 1'b0;
    inv_cipher_reset  = 1'b1;
    inv_cipher_enable = 1'b0;
    case (state_q)
      S_RUN_ENC: begin
        key_load      = 1'b0;
        cipher_reset  = 1'b0;
        cipher_enable = 1'b1;
      end
      S_EXPAND: begin
        key_load = 1'b0;
      end
      S_REV: begin
        key_load   = 1'b0;
        key_revers = 1'b1;
      end
      S_RUN_DEC: begin
        key_load          = 1'b0;
        key_revers        = 1'b1;
        inv_cipher_reset  = 1'b0;
        inv_cipher_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt_a     = gntA_q;
  assign gnt_b     = gntB_q;
  assign done_a    = doneA_q;
  assign done_b    = doneB_q;
  assign err_a     = errA_q;
  assign err_b     = errB_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign core_mode = mode_q;

endmodule
